// File: rtl/ssd_scan_scheduler.sv
// ssd_scan_scheduler: time-slot scan sequencer for a 4-digit multiplexed seven-segment display.
// Each digit slot is 16 PWM phases of PHASE_CYCLES clocks. Inside its slot a digit is lit
// according to per-digit enable, blink, leading-zero blanking and a 16-level brightness.
// Content and config updates arrive on a valid/ready port. They are held in a shadow register
// and committed only at a frame boundary, so a frame never mixes old and new content.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   upd_valid_i/ready_o update handshake
//   upd_digits_i        BCD digits {d3,d2,d1,d0}, d0 = ones
//   upd_mask_i          per-digit enable (1 = may light)
//   upd_blink_i         per-digit blink enable
//   upd_bright_i        brightness 0..15 (15 = full duty, 0 = 1/16)
//   upd_lzb_i           leading-zero blanking enable
//   digit_o             BCD value of the digit in the current slot
//   an_o                anode enables, active-low, one-hot-low when lit
//   frame_start_o       1-cycle pulse coincident with the first slot-0 output cycle
module ssd_scan_scheduler #(
   parameter int unsigned PHASE_CYCLES = 3125,
   parameter int unsigned BLINK_FRAMES = 125
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid_i,
   output logic        upd_ready_o,
   input  logic [15:0] upd_digits_i,
   input  logic [3:0]  upd_mask_i,
   input  logic [3:0]  upd_blink_i,
   input  logic [3:0]  upd_bright_i,
   input  logic        upd_lzb_i,
   output logic [3:0]  digit_o,
   output logic [3:0]  an_o,
   output logic        frame_start_o
);

   localparam int unsigned PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam int unsigned BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_CYCLES - 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_FRAMES - 1);

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  mask;
      logic [3:0]  blink;
      logic [3:0]  bright;
      logic        lzb;
   } cfg_t;

   localparam cfg_t CFG_RESET = '{digits: 16'h0000, mask: 4'hF, blink: 4'h0,
                                  bright: 4'hF, lzb: 1'b0};

   typedef enum logic {ST_EMPTY, ST_PENDING} upd_state_e;

   logic [PH_W-1:0] phase_cnt_q;
   logic [3:0]      phase_idx_q;
   logic [1:0]      slot_q;
   logic [BL_W-1:0] blink_cnt_q;
   logic            blink_ph_q;
   logic            phase_wrap, slot_adv, frame_bnd;

   upd_state_e      state_q, state_d;
   cfg_t            shadow_q, shadow_d;
   cfg_t            active_q, active_d;
   logic            ready_q, ready_d;

   logic [3:0]      an_q, an_d;
   logic [3:0]      digit_q, digit_d;
   logic            fs_q, fs_d;
   logic [3:0]      lzb_blank;
   logic            lit;

   assign phase_wrap = (phase_cnt_q == PH_LAST);
   assign slot_adv   = phase_wrap && (phase_idx_q == 4'd15);
   assign frame_bnd  = slot_adv && (slot_q == 2'd3);

   // Scan counters: phase cycle -> PWM phase -> slot -> blink frame count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_cnt_q <= '0;
         phase_idx_q <= '0;
         slot_q      <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
      end else begin
         phase_cnt_q <= phase_wrap ? '0 : phase_cnt_q + PH_W'(1);
         if (phase_wrap) phase_idx_q <= phase_idx_q + 4'd1;
         if (slot_adv)   slot_q      <= slot_q + 2'd1;
         if (frame_bnd) begin
            if (blink_cnt_q == BL_LAST) begin
               blink_cnt_q <= '0;
               blink_ph_q  <= ~blink_ph_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + BL_W'(1);
            end
         end
      end
   end

   // Update FSM state and config registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         shadow_q <= '0;
         active_q <= CFG_RESET;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         ready_q  <= ready_d;
      end
   end

   // Update FSM next state: capture into shadow, commit to active at frame boundary
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      ready_d  = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (upd_valid_i && ready_q) begin
               state_d  = ST_PENDING;
               shadow_d = '{digits: upd_digits_i, mask: upd_mask_i, blink: upd_blink_i,
                            bright: upd_bright_i, lzb: upd_lzb_i};
            end
         end
         ST_PENDING: begin
            if (frame_bnd) begin
               state_d  = ST_EMPTY;
               active_d = shadow_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      ready_d = (state_d == ST_EMPTY);
   end

   // A digit is leading-zero blanked when it and every more significant digit are zero
   always_comb begin
      lzb_blank    = 4'b0000;
      lzb_blank[3] = active_q.lzb && (active_q.digits[15:12] == 4'd0);
      lzb_blank[2] = lzb_blank[3] && (active_q.digits[11:8] == 4'd0);
      lzb_blank[1] = lzb_blank[2] && (active_q.digits[7:4]  == 4'd0);
   end

   // Display outputs, computed from the current counter state and registered
   always_comb begin
      lit     = active_q.mask[slot_q]
                && !(active_q.blink[slot_q] && blink_ph_q)
                && !lzb_blank[slot_q]
                && (phase_idx_q <= active_q.bright);
      an_d    = lit ? ~(4'b0001 << slot_q) : 4'b1111;
      digit_d = active_q.digits[{slot_q, 2'b00} +: 4];
      fs_d    = (slot_q == 2'd0) && (phase_idx_q == 4'd0) && (phase_cnt_q == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q    <= 4'b1111;
         digit_q <= 4'd0;
         fs_q    <= 1'b0;
      end else begin
         an_q    <= an_d;
         digit_q <= digit_d;
         fs_q    <= fs_d;
      end
   end

   assign an_o          = an_q;
   assign digit_o       = digit_q;
   assign frame_start_o = fs_q;
   assign upd_ready_o   = ready_q;

endmodule
